// File: rtl/aes128_input_masker.sv
// rtl/aes128_input_masker.sv - splits an unmasked 128-bit block into Boolean shares, one byte per beat
module aes128_input_masker #(
    parameter  int NUM_SHARES = 2,
    localparam int RAND_W     = (NUM_SHARES - 1) * 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [127:0]            in_data_i,
    input  logic                    rand_valid_i,
    output logic                    rand_ready_o,
    input  logic [RAND_W-1:0]       rand_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [8*NUM_SHARES-1:0] out_shares_o,
    output logic [3:0]              out_idx_o,
    output logic                    out_last_o
);

    generate
        if (NUM_SHARES < 2 || NUM_SHARES > 5) begin : g_bad_shares
            $error("aes128_input_masker: NUM_SHARES must be in 2..5");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_SHARE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [127:0]            block_q;
    logic                    accept;
    logic                    fire;
    logic [7:0]              cur_byte;
    logic [7:0]              mask;
    logic [8*NUM_SHARES-1:0] shares_d;

    assign in_ready_o   = (state_q == S_IDLE);
    assign accept       = in_valid_i && in_ready_o;
    assign fire         = (state_q == S_SHARE) && rand_valid_i && (!out_valid_o || out_ready_i);
    assign rand_ready_o = fire;
    assign cur_byte     = block_q[{cnt_q, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHARE;
            S_SHARE: if (fire && cnt_q == 4'd15) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Share 0 is the only one touching the secret, and only via the registered output.
    always_comb begin
        mask     = 8'h00;
        shares_d = '0;
        for (int s = 1; s < NUM_SHARES; s++) begin
            shares_d[8*s +: 8] = rand_i[8*(s-1) +: 8];
            mask               = mask ^ rand_i[8*(s-1) +: 8];
        end
        shares_d[7:0] = cur_byte ^ mask;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            block_q      <= '0;
            out_valid_o  <= 1'b0;
            out_shares_o <= '0;
            out_idx_o    <= 4'd0;
            out_last_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                block_q <= in_data_i;
                cnt_q   <= 4'd0;
            end
            if (fire) begin
                out_shares_o <= shares_d;
                out_idx_o    <= cnt_q;
                out_last_o   <= (cnt_q == 4'd15);
                out_valid_o  <= 1'b1;
                cnt_q        <= cnt_q + 4'd1;
                if (cnt_q == 4'd15) block_q <= '0;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
